// File: rtl/servant_uart_pkg.sv
// ============================================================================
// servant_uart_pkg : shared receive FSM state, register map and STATUS bits
// Revision 1.0
// ============================================================================
`default_nettype none

package servant_uart_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   localparam logic c_ADR_DATA   = 1'b0;
   localparam logic c_ADR_STATUS = 1'b1;

   localparam int c_ST_VALID     = 0;
   localparam int c_ST_OVERRUN   = 1;
   localparam int c_ST_FRAME_ERR = 2;
   localparam int c_ST_IRQ_EN    = 3;

endpackage

`default_nettype wire

// File: rtl/servant_uart_rx_core.sv
// ============================================================================
// servant_uart_rx_core : rx synchronizer, 8N1 receive FSM and shift register
// Revision 1.0
// ============================================================================
`default_nettype none

module servant_uart_rx_core
   import servant_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 139
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       strobe_o,
   output logic       frame_err_o
);

   localparam logic [15:0] c_CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] c_CNT_FULL = 16'(CLKS_PER_BIT - 1);

   logic [1:0]  sync_q;
   rx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bitn_q, bitn_d;
   logic [7:0]  shift_q, shift_d;

   logic w_rx;
   logic w_expire;

   assign w_rx     = sync_q[1];
   assign w_expire = (cnt_q == 16'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         state_q <= RX_IDLE;
         cnt_q   <= 16'd0;
         bitn_q  <= 3'd0;
         shift_q <= 8'd0;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bitn_q  <= bitn_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = w_expire ? cnt_q : cnt_q - 16'd1;
      bitn_d  = bitn_q;
      shift_d = shift_q;
      case (state_q)
         RX_IDLE: begin
            if (!w_rx) begin
               state_d = RX_START;
               cnt_d   = c_CNT_HALF;
            end
         end
         // Mid-start-bit recheck rejects short low glitches.
         RX_START: begin
            if (w_expire) begin
               if (w_rx) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_DATA;
                  cnt_d   = c_CNT_FULL;
                  bitn_d  = 3'd0;
               end
            end
         end
         RX_DATA: begin
            if (w_expire) begin
               shift_d = {w_rx, shift_q[7:1]};
               cnt_d   = c_CNT_FULL;
               bitn_d  = bitn_q + 3'd1;
               if (bitn_q == 3'd7) begin
                  state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (w_expire) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      byte_o      = shift_q;
      strobe_o    = 1'b0;
      frame_err_o = 1'b0;
      if (state_q == RX_STOP && w_expire) begin
         strobe_o    = 1'b1;
         frame_err_o = ~w_rx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/servant_uart_rx.sv
// ============================================================================
// servant_uart_rx : Wishbone DATA/STATUS wrapper around the 8N1 receiver
// Optional o_irq output and STATUS irq-enable bit: SERVANT_UART_RX_IRQ_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module servant_uart_rx
   import servant_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 139
) (
   input  logic        i_wb_clk,
   input  logic        i_wb_rst,
   input  logic        i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   input  logic        i_rx
`ifdef SERVANT_UART_RX_IRQ_EN
   ,
   output logic        o_irq
`endif
);

   logic [7:0]  w_byte;
   logic        w_strobe;
   logic        w_frame_err;

   servant_uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_core (
      .clk_i       (i_wb_clk),
      .rst_i       (i_wb_rst),
      .rx_i        (i_rx),
      .byte_o      (w_byte),
      .strobe_o    (w_strobe),
      .frame_err_o (w_frame_err)
   );

   logic [7:0]  hold_q, hold_d;
   logic        valid_q, valid_d;
   logic        ovr_q, ovr_d;
   logic        ferr_q, ferr_d;
   logic        ack_q, ack_d;
   logic [31:0] rdt_q, rdt_d;
   logic        w_irq_en;
   logic        w_irq_en_d;

   logic        w_acc;
   logic        w_rd_data;
   logic        w_wr_status;
   logic [31:0] w_status;

`ifdef SERVANT_UART_RX_IRQ_EN
   logic irq_en_q;
   logic irq_q;
   logic w_unused;
   assign w_irq_en   = irq_en_q;
   assign w_irq_en_d = w_wr_status ? i_wb_dat[c_ST_IRQ_EN] : irq_en_q;
   assign w_unused   = ^{i_wb_dat[31:4], i_wb_dat[0]};
   assign o_irq      = irq_q;

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= w_irq_en_d;
         irq_q    <= valid_d & w_irq_en_d;
      end
   end
`else
   logic w_unused;
   assign w_irq_en   = 1'b0;
   assign w_irq_en_d = 1'b0;
   assign w_unused   = ^{i_wb_dat[31:3], i_wb_dat[0], w_irq_en_d};
`endif

   assign w_acc       = i_wb_cyc & ~ack_q;
   assign w_rd_data   = w_acc & ~i_wb_we & (i_wb_adr == c_ADR_DATA);
   assign w_wr_status = w_acc &  i_wb_we & (i_wb_adr == c_ADR_STATUS);
   assign w_status    = {28'd0, w_irq_en, ferr_q, ovr_q, valid_q};

   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = ferr_q;
      ack_d   = w_acc;
      rdt_d   = 32'd0;

      if (w_acc && !i_wb_we) begin
         rdt_d = (i_wb_adr == c_ADR_DATA) ? {24'd0, hold_q} : w_status;
      end
      if (w_rd_data) begin
         valid_d = 1'b0;
      end
      if (w_wr_status && i_wb_dat[c_ST_OVERRUN]) begin
         ovr_d = 1'b0;
      end
      if (w_wr_status && i_wb_dat[c_ST_FRAME_ERR]) begin
         ferr_d = 1'b0;
      end
      // A byte landing in the same cycle as a DATA read is not an overrun:
      // the reader takes the old byte and the new one stays valid.
      if (w_strobe) begin
         hold_d  = w_byte;
         valid_d = 1'b1;
         if (valid_q && !w_rd_data) begin
            ovr_d = 1'b1;
         end
         if (w_frame_err) begin
            ferr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         hold_q  <= 8'd0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ack_q   <= 1'b0;
         rdt_q   <= 32'd0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         ack_q   <= ack_d;
         rdt_q   <= rdt_d;
      end
   end

   assign o_wb_ack = ack_q;
   assign o_wb_rdt = rdt_q;

endmodule

`default_nettype wire

// File: tb/tb_servant_uart_rx.sv
// ============================================================================
// tb_servant_uart_rx : table-driven bench with read-data scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_servant_uart_rx;
   import servant_uart_pkg::*;

   localparam int CPB = 16;
`ifdef SERVANT_UART_RX_IRQ_EN
   localparam logic [31:0] IRQ_RB = 32'h8;
`else
   localparam logic [31:0] IRQ_RB = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        adr = 1'b0;
   logic [31:0] wdat = 32'd0;
   logic        we = 1'b0;
   logic        cyc = 1'b0;
   logic [31:0] rdt;
   logic        ack;
   logic        rx = 1'b1;
`ifdef SERVANT_UART_RX_IRQ_EN
   logic        irq;
`endif

   servant_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_wb_clk (clk),
      .i_wb_rst (rst),
      .i_wb_adr (adr),
      .i_wb_dat (wdat),
      .i_wb_we  (we),
      .i_wb_cyc (cyc),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .i_rx     (rx)
`ifdef SERVANT_UART_RX_IRQ_EN
      ,
      .o_irq    (irq)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] sb[$];

   typedef enum int {OP_SEND, OP_RD, OP_WR} op_e;
   typedef struct {
      op_e         op;
      logic        adr;
      logic [31:0] val;
      logic [31:0] exp;
      logic        stop;
      string       name;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(op_e op, logic a, logic [31:0] v, logic [31:0] e, logic s, string n);
      vec_t t;
      t.op = op; t.adr = a; t.val = v; t.exp = e; t.stop = s; t.name = n;
      return t;
   endfunction

   task automatic bus(input logic a, input logic w, input logic [31:0] d,
                      input logic [31:0] e, input string name);
      int n;
      @(negedge clk);
      adr = a; we = w; wdat = d; cyc = 1'b1;
      if (!w) sb.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 8);
      chk({name, " ack"}, 32'(ack), 32'd1);
      if (!w) chk(name, rdt, sb.pop_front());
      cyc = 1'b0; we = 1'b0;
      @(negedge clk);
      chk({name, " idle"}, {rdt[30:0], ack}, 32'd0);
   endtask

   // k counts negedges from the start-bit edge; the stop-bit sample lands
   // on the posedge right after negedge 154 when CPB = 16.
   task automatic send(input logic [7:0] b, input logic stop, input int rd_at, input int rst_at);
      for (int k = 0; k < 10 * CPB; k++) begin
         @(negedge clk);
         if (k < CPB)            rx = 1'b0;
         else if (k < 9 * CPB)   rx = b[(k - CPB) / CPB];
         else                    rx = stop;
         if (k == rd_at) begin
            adr = c_ADR_DATA; we = 1'b0; cyc = 1'b1;
            sb.push_back(32'h11);
         end
         if (rd_at >= 0 && k == rd_at + 1) begin
            chk("coincident read ack", 32'(ack), 32'd1);
            chk("coincident read data", rdt, sb.pop_front());
`ifdef SERVANT_UART_RX_IRQ_EN
            chk("coincident irq", 32'(irq), 32'd1);
`endif
            cyc = 1'b0;
         end
         if (k == rst_at) begin
            rst = 1'b1; cyc = 1'b1; adr = c_ADR_DATA; we = 1'b0;
         end
         if (rst_at >= 0 && k == rst_at + 2) begin
            chk("reset ack", 32'(ack), 32'd0);
            chk("reset rdt", rdt, 32'd0);
            rx = 1'b1;
         end
         if (rst_at >= 0 && k == rst_at + 3) begin
            rst = 1'b0; cyc = 1'b0;
            break;
         end
      end
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs.push_back(mk(OP_SEND, 0, 32'hA5, 0, 1, "tx A5"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h1, 0, "A5 status"));
      vecs.push_back(mk(OP_RD, c_ADR_DATA, 0, 32'hA5, 0, "A5 data"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h0, 0, "A5 status after"));
      vecs.push_back(mk(OP_SEND, 0, 32'h3C, 0, 1, "tx 3C"));
      vecs.push_back(mk(OP_SEND, 0, 32'h7E, 0, 1, "tx 7E"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h3, 0, "overrun status"));
      vecs.push_back(mk(OP_RD, c_ADR_DATA, 0, 32'h7E, 0, "overrun data"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h2, 0, "overrun kept"));
      vecs.push_back(mk(OP_WR, c_ADR_STATUS, 32'h2, 0, 0, "clear overrun"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h0, 0, "overrun cleared"));
      vecs.push_back(mk(OP_SEND, 0, 32'h55, 0, 0, "tx 55 bad stop"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h5, 0, "frame err status"));
      vecs.push_back(mk(OP_RD, c_ADR_DATA, 0, 32'h55, 0, "frame err data"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h4, 0, "frame err kept"));
      vecs.push_back(mk(OP_WR, c_ADR_STATUS, 32'h4, 0, 0, "clear frame err"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h0, 0, "frame err cleared"));
      vecs.push_back(mk(OP_WR, c_ADR_DATA, 32'hFF, 0, 0, "data write"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, 32'h0, 0, "data write ignored"));
      vecs.push_back(mk(OP_WR, c_ADR_STATUS, 32'h8, 0, 0, "irq en write"));
      vecs.push_back(mk(OP_RD, c_ADR_STATUS, 0, IRQ_RB, 0, "irq en readback"));
      vecs.push_back(mk(OP_WR, c_ADR_STATUS, 32'h0, 0, 0, "irq en clear"));

      repeat (4) @(negedge clk);
      chk("reset ack", 32'(ack), 32'd0);
      chk("reset rdt", rdt, 32'd0);
      rst = 1'b0;
      bus(c_ADR_STATUS, 0, 0, 32'h0, "reset status");
      bus(c_ADR_DATA, 0, 0, 32'h0, "reset data");

      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_SEND: send(vecs[i].val[7:0], vecs[i].stop, -1, -1);
            OP_RD:   bus(vecs[i].adr, 1'b0, 32'd0, vecs[i].exp, vecs[i].name);
            default: bus(vecs[i].adr, 1'b1, vecs[i].val, 32'd0, vecs[i].name);
         endcase
      end

      // Short low pulse on the line must be rejected as a glitch.
      @(negedge clk); rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch fsm idle", 32'(dut.u_core.state_q), 32'(RX_IDLE));
      bus(c_ADR_STATUS, 0, 0, 32'h0, "glitch status");

      // Reset during data bit 4 with a pending byte, then a clean frame.
      send(8'h11, 1'b1, -1, -1);
      send(8'h5A, 1'b1, -1, 5 * CPB + 5);
      bus(c_ADR_STATUS, 0, 0, 32'h0, "post reset status");
      bus(c_ADR_DATA, 0, 0, 32'h0, "post reset data");
      send(8'h81, 1'b1, -1, -1);
      bus(c_ADR_STATUS, 0, 0, 32'h1, "81 status");
      bus(c_ADR_DATA, 0, 0, 32'h81, "81 data");

      // DATA read accepted on the exact stop-transfer edge.
      bus(c_ADR_STATUS, 1, 32'h8, 0, "irq en set");
      send(8'h11, 1'b1, -1, -1);
      send(8'h12, 1'b1, 9 * CPB + 10, -1);
      bus(c_ADR_STATUS, 0, 0, 32'h1 | IRQ_RB, "coincident status");
      bus(c_ADR_DATA, 0, 0, 32'h12, "coincident new data");
      bus(c_ADR_STATUS, 0, 0, IRQ_RB, "coincident status after");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/servant_uart_rx.md
SERVANT_UART_RX -- requirements
Module: servant_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 139, clock cycles per serial bit (16 MHz, 115200 baud); legal range 4..65535.
REQ-002 SHALL have port i_wb_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_wb_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_wb_adr  input  1  register select (CPU byte address bit 2): 0 = DATA, 1 = STATUS.
REQ-005 SHALL have port i_wb_dat  input  32  write data.
REQ-006 SHALL have port i_wb_we  input  1  write enable.
REQ-007 SHALL have port i_wb_cyc  input  1  bus cycle request, combined strobe.
REQ-008 SHALL have port o_wb_rdt  output  32  read data.
REQ-009 SHALL have port o_wb_ack  output  1  single-cycle acknowledge.
REQ-010 SHALL have port i_rx  input  1  asynchronous serial line, idle high, 8N1.

Function
REQ-011 i_rx SHALL pass a 2-flop synchronizer (flops reset to 1) before any use; all timing below counts from the synchronized signal.
REQ-012 Receive FSM states: IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on synchronized rx = 0; bit counter loaded with CLKS_PER_BIT/2 - 1 (floor).
REQ-014 START: at counter expiry, rx = 1 -> IDLE (glitch, nothing recorded); rx = 0 -> DATA, counter reloaded with CLKS_PER_BIT - 1.
REQ-015 DATA: at each expiry, sample rx into shift register LSB-first; after 8th sample -> STOP, counter reloaded with CLKS_PER_BIT - 1.
REQ-016 STOP: at expiry, sample rx; byte SHALL transfer to the holding register and valid SHALL set in the same cycle; frame_err SHALL set if sample = 0; -> IDLE.
REQ-017 If valid is already 1 at transfer, holding register SHALL be overwritten with the new byte and overrun SHALL set.
REQ-018 Read of DATA: o_wb_rdt = {24'b0, holding byte}; valid SHALL clear on the acked cycle.
REQ-019 Read of STATUS: o_wb_rdt = {29'b0, frame_err, overrun, valid}; no side effects.
REQ-020 Write of STATUS: bit 1 = 1 clears overrun, bit 2 = 1 clears frame_err; write to DATA SHALL be ignored but acked.
REQ-021 o_wb_ack SHALL be registered: ack <= i_wb_cyc & ~ack; one-cycle latency; back-to-back cycles ack every second clock.
REQ-022 Simultaneous DATA read-ack and STOP transfer: new byte SHALL be stored, valid SHALL remain 1, overrun SHALL NOT set; read returns the old byte.
REQ-023 Simultaneous STATUS clear-write and flag-setting event: the set SHALL win.
REQ-024 o_wb_rdt SHALL be registered with ack; value undefined-free (zero) when not acking.

Reset
REQ-025 On i_wb_rst: FSM = IDLE, counters = 0, holding byte = 0x00, valid/overrun/frame_err = 0, o_wb_ack = 0, o_wb_rdt = 0, synchronizer = 1.
REQ-026 Reset mid-frame SHALL abort the frame; a line still low after reset release SHALL be treated as a new start bit.

Configuration
REQ-027 Macro SERVANT_UART_RX_IRQ_EN defined: extra port o_irq  output  1, registered, = valid & STATUS bit 3 (irq enable, read/write, reset 0); STATUS read returns bit 3.
REQ-028 Macro undefined: no o_irq port, STATUS bit 3 reads 0 and ignores writes.

Structure
REQ-029 Shared package servant_uart_pkg SHALL hold FSM state typedef, register address constants and STATUS bit index constants.
REQ-030 Sub-module servant_uart_rx_core (sync + FSM + shifter, byte/strobe/frame_err out) is natural; Wishbone register wrapper in servant_uart_rx.

Verification
REQ-031 CLKS_PER_BIT = 16, send 0xA5 with valid stop -> STATUS reads 0x1, DATA reads 0x000000A5, next STATUS reads 0x0.
REQ-032 Send 0x3C then 0x7E without reading -> STATUS 0x3 (overrun), DATA 0x7E; write STATUS 0x2 -> STATUS 0x0 after DATA read.
REQ-033 Send 0x55 with stop bit held low -> STATUS bit 2 set, DATA 0x55; write 0x4 clears it.
REQ-034 Pulse i_rx low for 4 clocks (CLKS_PER_BIT = 16) -> no byte, STATUS stays 0x0, FSM back in IDLE.
REQ-035 Assert i_wb_rst during DATA bit 4 of a frame -> all outputs 0; release with line high -> next full 0x81 frame received correctly.
REQ-036 DATA read acked in exact STOP-transfer cycle of 0x12 (old byte 0x11) -> read 0x11, STATUS 0x1, DATA then 0x12; with SERVANT_UART_RX_IRQ_EN and bit 3 set, o_irq stays 1.
